// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer: command sequencer between an 18-byte UART frame
// interface and an AES-128 encryption core.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rx_frame, rx_valid  received frame (byte k = rx_frame[8k+7:8k]) and its
//                       one-cycle strobe; byte0 = cmd, byte17 = trailer,
//                       bytes16..1 = payload (byte16 is the MSB)
//   aes_key, aes_text_in, aes_ld        key, plaintext, load pulse to core
//   aes_done, aes_text_out              completion flag, ciphertext from core
//   tx_data, tx_send, tx_busy           response frame, send pulse, tx busy
//   busy, err                           not-idle flag, sticky error flag
//
// Optional build macro AES_SEQ_TIMEOUT_EN: bound the wait for aes_done to
// TIMEOUT_CYCLES cycles, then flag err and abort (responding with a zero
// payload for "F").
module aes_uart_sequencer #(
    parameter int FRAME_BYTES    = 18,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [143:0] rx_frame,
    input  logic         rx_valid,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    output logic         aes_ld,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out,
    output logic [143:0] tx_data,
    output logic         tx_send,
    input  logic         tx_busy,
    output logic         busy,
    output logic         err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT0     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] CAPTURE   = 3'd4;
    localparam logic [2:0] RESP      = 3'd5;
    localparam logic [2:0] SEND      = 3'd6;

    localparam logic [7:0] CMD_A = 8'h41;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_F = 8'h46;

    // Fixed "A" reply: bytes 1..15 are the ASCII digits "123456789012345".
    localparam logic [119:0] A_DIGITS = 120'h353433323130393837363534333231;

    if (FRAME_BYTES != 18) begin : g_bad_frame
        $error("aes_uart_sequencer supports only FRAME_BYTES = 18");
    end
    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("aes_uart_sequencer needs 2**TO_W > TIMEOUT_CYCLES");
    end

    logic [2:0]   state;
    logic [127:0] ct_reg;
    logic         res_valid;
    logic         auto_resp;

    logic [7:0]   cmd;
    logic [7:0]   trailer;
    logic [127:0] payload;
    logic         frame_ok;
    logic [7:0]   status;

    assign cmd      = rx_frame[7:0];
    assign trailer  = rx_frame[143:136];
    assign payload  = rx_frame[135:8];
    assign frame_ok = rx_valid && (cmd == trailer);
    assign status   = {6'b0, res_valid, err};

    assign aes_ld  = (state == LOAD);
    assign tx_send = (state == SEND);
    assign busy    = (state != IDLE);

`ifdef AES_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aes_key     <= '0;
            aes_text_in <= '0;
            tx_data     <= '0;
            err         <= 1'b0;
            ct_reg      <= '0;
            res_valid   <= 1'b0;
            auto_resp   <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            // Any frame arriving mid-command is dropped.
            if (rx_valid && (state != IDLE)) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_valid && !frame_ok) begin
                        err <= 1'b1;
                    end else if (frame_ok) begin
                        case (cmd)
                            CMD_A: begin
                                tx_data <= {CMD_A, 8'h00, A_DIGITS, CMD_A};
                                err     <= 1'b0;
                                state   <= RESP;
                            end
                            CMD_B: begin
                                tx_data <= {status, ct_reg, CMD_B};
                                state   <= RESP;
                            end
                            CMD_C: begin
                                aes_key   <= payload;
                                res_valid <= 1'b0;
                            end
                            CMD_D: begin
                                aes_text_in <= payload;
                                res_valid   <= 1'b0;
                            end
                            CMD_E: begin
                                auto_resp <= 1'b0;
                                state     <= LOAD;
                            end
                            CMD_F: begin
                                auto_resp <= 1'b1;
                                state     <= LOAD;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end

                LOAD: state <= WAIT0;

                // The core's done is still high from the previous run here.
                WAIT0: begin
`ifdef AES_SEQ_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (aes_done) begin
                        state <= CAPTURE;
`ifdef AES_SEQ_TIMEOUT_EN
                    end else if (to_hit) begin
                        err <= 1'b1;
                        if (auto_resp) begin
                            tx_data <= {6'b0, res_valid, 1'b1, 128'h0, CMD_F};
                            state   <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end

                // The response reports the fresh result, so build its
                // status with result-valid already set.
                CAPTURE: begin
                    ct_reg    <= aes_text_out;
                    res_valid <= 1'b1;
                    if (auto_resp) begin
                        tx_data <= {6'b0, 1'b1, err, aes_text_out, CMD_B};
                        state   <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end

                RESP: begin
                    if (!tx_busy) begin
                        state <= SEND;
                    end
                end

                SEND: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// tb_aes_uart_sequencer: directed self-checking bench for aes_uart_sequencer.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_aes_uart_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] rx_frame;
    logic         rx_valid;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_ld;
    logic         aes_done;
    logic [127:0] aes_text_out;
    logic [143:0] tx_data;
    logic         tx_send;
    logic         tx_busy;
    logic         busy;
    logic         err;

    int errors = 0;
    int checks = 0;

    localparam logic [143:0] EXP_A =
        144'h4100_3534_3332_3130_3938_3736_3534_3332_3141;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_uart_sequencer #(
        .FRAME_BYTES(18),
        .TIMEOUT_CYCLES(16),
        .TO_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_frame(rx_frame),
        .rx_valid(rx_valid),
        .aes_key(aes_key),
        .aes_text_in(aes_text_in),
        .aes_ld(aes_ld),
        .aes_done(aes_done),
        .aes_text_out(aes_text_out),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_busy(tx_busy),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] mk(input logic [7:0] c,
                                        input logic [127:0] p,
                                        input logic [7:0] t);
        return {t, p, c};
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [143:0] f);
        rx_frame = f;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_frame = '1;
    endtask

    int n_ld;
    int n_send;

    initial begin
        rst          = 1'b1;
        rx_frame     = '0;
        rx_valid     = 1'b0;
        aes_done     = 1'b0;
        aes_text_out = '0;
        tx_busy      = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("reset_ctl", 144'({busy, err, tx_send, aes_ld}), 144'h0);
        chk("reset_tx_data", tx_data, 144'h0);
        chk("reset_key_pt", 144'(aes_key | aes_text_in), 144'h0);

`ifdef AES_SEQ_TIMEOUT_EN
        // Timeout: F with aes_done held low, 16 WAIT_DONE cycles.
        send(mk(8'h46, 128'h0, 8'h46));
        chk("to_ld", 144'(aes_ld), 144'h1);
        step();
        repeat (16) step();
        chk("to_still_wait", 144'({busy, err}), 144'h2);
        step();
        chk("to_err", 144'({busy, err, tx_send}), 144'h6);
        step();
        chk("to_send", 144'(tx_send), 144'h1);
        chk("to_tx_data", tx_data, {8'h01, 128'h0, 8'h46});
        step();
        chk("to_idle", 144'(busy), 144'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        // "A" frame: send pulse two cycles after the frame.
        send(mk(8'h41, 128'hdead, 8'h41));
        chk("a_busy_cyc1", 144'({busy, tx_send}), 144'h2);
        step();
        chk("a_send", 144'(tx_send), 144'h1);
        chk("a_tx_data", tx_data, EXP_A);
        step();
        chk("a_done", 144'({busy, tx_send, err}), 144'h0);

        // "B" after reset: zero ciphertext, status 00.
        send(mk(8'h42, 128'h0, 8'h42));
        step();
        chk("b_send", 144'(tx_send), 144'h1);
        chk("b_tx_data", tx_data, {8'h00, 128'h0, 8'h42});
        step();

        // Load key and plaintext.
        send(mk(8'h43, KEY, 8'h43));
        chk("c_key", 144'(aes_key), 144'(KEY));
        chk("c_idle", 144'(busy), 144'h0);
        send(mk(8'h44, PT, 8'h44));
        chk("d_pt", 144'(aes_text_in), 144'(PT));

        // "F": one load pulse, wait for done, auto response.
        n_ld = 0;
        send(mk(8'h46, 128'h0, 8'h46));
        chk("f_ld_pulse", 144'(aes_ld), 144'h1);
        step();
        repeat (4) begin
            n_ld += int'(aes_ld);
            step();
        end
        chk("f_no_extra_ld", 144'(n_ld), 144'h0);
        aes_text_out = CT;
        aes_done     = 1'b1;
        step();
        aes_done = 1'b0;
        step();
        chk("f_resp_wait", 144'({busy, tx_send}), 144'h2);
        step();
        chk("f_send", 144'(tx_send), 144'h1);
        chk("f_tx_data", tx_data, {8'h02, CT, 8'h42});
        step();
        chk("f_idle", 144'({busy, tx_send}), 144'h0);

        // Bad trailer: err set, nothing started; "A" clears err.
        send(mk(8'h45, 128'h0, 8'h58));
        chk("bad_err", 144'({err, aes_ld, busy}), 144'h4);
        send(mk(8'h41, 128'h0, 8'h41));
        chk("a_clears_err", 144'(err), 144'h0);
        step();
        step();

        // Unknown command with matching trailer.
        send(mk(8'h5a, 128'h0, 8'h5a));
        chk("unk_err", 144'({err, busy}), 144'h2);
        send(mk(8'h41, 128'h0, 8'h41));
        step();
        step();

        // "F" with tx_busy high for 50 cycles.
        tx_busy = 1'b1;
        n_send  = 0;
        send(mk(8'h46, 128'h0, 8'h46));
        step();
        step();
        aes_text_out = CT ^ 128'h1;
        aes_done     = 1'b1;
        step();
        aes_done = 1'b0;
        repeat (50) begin
            step();
            n_send += int'(tx_send);
        end
        chk("busy_hold_no_send", 144'({n_send, busy}), 144'h1);
        tx_busy = 1'b0;
        step();
        chk("busy_release_send", 144'(tx_send), 144'h1);
        chk("busy_tx_data", tx_data, {8'h02, CT ^ 128'h1, 8'h42});
        step();
        chk("busy_one_pulse", 144'({tx_send, busy}), 144'h0);

        // Valid "E" while busy: dropped, err set, one load only.
        n_ld = 0;
        send(mk(8'h45, 128'h0, 8'h45));
        n_ld += int'(aes_ld);
        send(mk(8'h45, 128'h0, 8'h45));
        chk("drop_err", 144'({err, busy}), 144'h3);
        repeat (5) begin
            n_ld += int'(aes_ld);
            step();
        end
        chk("drop_single_ld", 144'(n_ld), 144'h1);

        // Reset while in WAIT_DONE.
        rst = 1'b1;
        step();
        chk("rst_ctl", 144'({busy, err, tx_send, aes_ld}), 144'h0);
        chk("rst_tx_data", tx_data, 144'h0);
        chk("rst_key_pt", 144'(aes_key | aes_text_in), 144'h0);
        rst = 1'b0;
        step();
        chk("rst_stays_idle", 144'({busy, aes_ld}), 144'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_uart_sequencer.md
Name: aes_uart_sequencer

Overview:
- Command sequencer between the 18-byte UART frame interface and the AES-128 encryption core.
- Validates each received frame and latches key/plaintext from it.
- Pulses the core's load, waits for completion and captures the ciphertext.
- Builds response frames and triggers the UART transmitter, with a tx-busy handshake.
- Replaces ad-hoc per-cycle frame decoding in the top level with a single-pass, one-command-per-frame FSM.

Parameters:
- FRAME_BYTES, 18, UART frame length in bytes. Fixed layout; only 18 is supported.
- TIMEOUT_CYCLES, 1024, cycles to wait for aes_done before aborting. Used only with AES_SEQ_TIMEOUT_EN.
- TO_W, 11, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; also clocks the AES core.
- rst  in  1  synchronous active-high reset.
- rx_frame  in  144  received frame. Byte k = rx_frame[8k+7:8k]. Byte0 = command, byte17 = trailer, bytes1..16 = payload.
- rx_valid  in  1  one-cycle pulse when a new complete frame is present on rx_frame.
- aes_key  out  128  key to core.
- aes_text_in  out  128  plaintext to core.
- aes_ld  out  1  one-cycle load/start pulse to core.
- aes_done  in  1  core completion flag.
- aes_text_out  in  128  ciphertext from core.
- tx_data  out  144  response frame, same byte layout as rx_frame.
- tx_send  out  1  one-cycle transmit trigger.
- tx_busy  in  1  transmitter busy; tx_send is never asserted while high.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared by rst or by a valid "A" frame.

Behaviour:
- Reset values: aes_key=0, aes_text_in=0, aes_ld=0, tx_data=0, tx_send=0, busy=0, err=0, ct_reg=0, state=IDLE.
- Frame valid when rx_valid=1 and byte17==byte0.
  - Invalid frame sets err. No other effect.
- Frames arriving while busy=1 are dropped and set err.
- rx_frame is sampled only in the cycle rx_valid=1; later changes are ignored.
- States: IDLE, LOAD, WAIT0, WAIT_DONE, CAPTURE, RESP, SEND.
- IDLE, on a valid frame, by cmd byte:
  - "A": tx_data <= {"A","123456789012345",8'h00,"A"} (trailer byte17 = cmd). Clear err. Go to RESP.
  - "B": tx_data <= {"B", ct_reg, status}. Go to RESP.
  - "C": aes_key <= payload (bytes16..1, byte16 = MSB). Stay IDLE.
  - "D": aes_text_in <= payload. Stay IDLE.
  - "E": go to LOAD; no response.
  - "F": go to LOAD; auto-respond as "B" after CAPTURE.
  - Any other cmd: set err, stay IDLE.
- status byte: bit0 = err, bit1 = result valid (set at CAPTURE, cleared by "C"/"D"), others 0.
- LOAD: aes_ld=1 for exactly one cycle; next state WAIT0.
- WAIT0: one-cycle guard; aes_done is ignored here because the core's done deasserts a cycle after ld. Next state WAIT_DONE.
- WAIT_DONE: stay while aes_done=0. On aes_done=1 go to CAPTURE.
- CAPTURE: ct_reg <= aes_text_out; set result-valid.
  - Command "E": return to IDLE.
  - Command "F": load tx_data as for "B", go to RESP.
- RESP: wait while tx_busy=1. When tx_busy=0, go to SEND.
- SEND: tx_send=1 for exactly one cycle; return to IDLE.
- Latency: "A"/"B" valid frame -> tx_send after exactly 2 cycles if tx_busy=0. "E" -> aes_ld 1 cycle after the frame.
- Reset mid-operation: return to IDLE immediately, all outputs to reset values. In-flight core result is discarded.
- rst and rx_valid in the same cycle: rst wins.
- aes_key/aes_text_in change only on "C"/"D" in IDLE, so they are stable during encryption.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT_DONE, incremented each cycle there.
  - Reaching TIMEOUT_CYCLES sets err and returns to IDLE; for "F", sends {"F",128'h0,status} instead.
  - aes_done in the same cycle as the terminal count: done wins.
- Undefined: no counter; WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then "A" frame with tx_busy=0 -> tx_send pulse 2 cycles later; tx_data bytes0..15 = "A123456789012345", byte16 = 00, byte17 = "A"; err=0.
- "C" with key 000102..0F, "D" with plaintext 00112233445566778899AABBCCDDEEFF, then "F" -> one aes_ld pulse; core done; tx_data payload = 69C4E0D86A7B0430D8CDB78070B4C55A; status = 02.
- Frame with byte0="E", byte17="X" -> err=1, no aes_ld; then "A" -> err=0.
- "F" with tx_busy held high 50 cycles -> no tx_send until tx_busy falls, then exactly one pulse.
- Valid "E" while busy=1 -> frame dropped, err=1, single aes_ld total. rst asserted during WAIT_DONE -> all outputs 0 the next cycle.
- AES_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, aes_done tied 0, "F" -> after 16 WAIT_DONE cycles, err=1 and response payload all zeros with status 01.
